iq_symbol_mapper: RTL and testbench

- Upstream feeder for the I/Q modulator.
- Accepts a serial bit stream over a valid/ready handshake, groups bits into QPSK or 16-QAM symbols, and Gray-maps them to signed 8-bit I/Q levels.
- Holds each I/Q pair for exactly CLKS_PER_SYM clocks.
- Double-buffered (assembly register plus holding register), so bits for the next symbol arrive while the current one is transmitted.

---
 rtl/iq_symbol_mapper.sv | 214 +++++++++++++++++++++
 tb/tb_iq_symbol_mapper.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_symbol_mapper.sv
// Serial-bit to QPSK / 16-QAM Gray-mapped I/Q symbol source with an assembly + holding buffer.
// Each I/Q pair is held for CLKS_PER_SYM clocks; an empty holding buffer at a boundary emits 0/0.
module iq_symbol_mapper #(
    parameter int unsigned CLKS_PER_SYM = 32,
    parameter int unsigned AMP          = 120
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              enable,
    input  logic              mode,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic signed [7:0] i,
    output logic signed [7:0] q,
    output logic              sym_strobe,
    output logic              underrun
);

    localparam int unsigned CntW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_SYM - 1);
    localparam logic signed [7:0] LvlOuter = 8'(AMP);
    localparam logic signed [7:0] LvlInner = 8'(AMP / 3);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [3:0]        asm_q, asm_d;
    logic [2:0]        asm_cnt_q, asm_cnt_d;
    logic              asm_full_q, asm_full_d;
    logic [3:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic signed [7:0] i_q, i_d;
    logic signed [7:0] q_q, q_d;
    logic              strobe_q, strobe_d;
    logic              underrun_q, underrun_d;

    logic              accept;
    logic              consume;
    logic              transfer;
    logic [2:0]        bits_per_sym;
    logic [3:0]        asm_base;
    logic [2:0]        cnt_base;
    logic signed [7:0] i_load;
    logic signed [7:0] q_load;

    function automatic logic signed [7:0] gray_level(input logic [1:0] g);
        logic signed [7:0] lvl;
        unique case (g)
            2'b00:   lvl = -LvlOuter;
            2'b01:   lvl = -LvlInner;
            2'b11:   lvl = LvlInner;
            default: lvl = LvlOuter;
        endcase
        return lvl;
    endfunction

    function automatic logic signed [7:0] qpsk_level(input logic b);
        return b ? LvlOuter : -LvlOuter;
    endfunction

    // Bits are never taken in IDLE, so bit_ready is also low throughout reset.
    assign bit_ready = enable && (state_q != StIdle) && !(asm_full_q && hold_full_q);
    assign accept    = bit_valid && bit_ready;

    always_comb begin
        i_load = '0;
        q_load = '0;
        if (mode_q) begin
            i_load = gray_level(hold_q[3:2]);
            q_load = gray_level(hold_q[1:0]);
        end else begin
            i_load = qpsk_level(hold_q[1]);
            q_load = qpsk_level(hold_q[0]);
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        q_d        = q_q;
        strobe_d   = 1'b0;
        underrun_d = underrun_q;
        consume    = 1'b0;

        if (state_q == StIdle) begin
            mode_d = mode;
        end

        if (!enable) begin
            state_d    = StIdle;
            cnt_d      = '0;
            i_d        = '0;
            q_d        = '0;
            underrun_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPrime;
                    cnt_d   = '0;
                    i_d     = '0;
                    q_d     = '0;
                end
                StPrime: begin
                    if (hold_full_q) begin
                        i_d      = i_load;
                        q_d      = q_load;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                        consume  = 1'b1;
                        state_d  = StRun;
                    end
                end
                StRun: begin
                    if (cnt_q == CntLast) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        if (hold_full_q) begin
                            i_d     = i_load;
                            q_d     = q_load;
                            consume = 1'b1;
                        end else begin
                            i_d        = '0;
                            q_d        = '0;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bits_per_sym = mode_q ? 3'd4 : 3'd2;
        transfer     = asm_full_q && (!hold_full_q || consume);

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (transfer) begin
            hold_d      = asm_q;
            hold_full_d = 1'b1;
        end

        // A bit accepted alongside a transfer is the first bit of the next symbol.
        asm_base   = transfer ? 4'd0 : asm_q;
        cnt_base   = transfer ? 3'd0 : asm_cnt_q;
        asm_d      = asm_base;
        asm_cnt_d  = cnt_base;
        asm_full_d = asm_full_q && !transfer;
        if (accept) begin
            asm_d      = {asm_base[2:0], bit_in};
            asm_cnt_d  = cnt_base + 3'd1;
            asm_full_d = ((cnt_base + 3'd1) == bits_per_sym);
        end

        if (!enable || (state_q == StIdle)) begin
            asm_d       = '0;
            asm_cnt_d   = '0;
            asm_full_d  = 1'b0;
            hold_d      = '0;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            asm_q       <= '0;
            asm_cnt_q   <= '0;
            asm_full_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            i_q         <= '0;
            q_q         <= '0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            asm_q       <= asm_d;
            asm_cnt_q   <= asm_cnt_d;
            asm_full_q  <= asm_full_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            q_q         <= q_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign i          = i_q;
    assign q          = q_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_iq_symbol_mapper.sv
// Directed and randomized checks of iq_symbol_mapper against a constellation-level reference.
// dut_a runs at 32 clocks/symbol, dut_b at 4 clocks/symbol for the backpressure stream.
module tb_iq_symbol_mapper;

    localparam int AMP   = 120;
    localparam int INNER = AMP / 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              a_en, a_mode, a_bit, a_val, a_rdy, a_stb, a_und;
    logic signed [7:0] a_i, a_q;
    logic              b_en, b_mode, b_bit, b_val, b_rdy, b_stb, b_und;
    logic signed [7:0] b_i, b_q;

    iq_symbol_mapper #(.CLKS_PER_SYM(32), .AMP(AMP)) dut_a (
        .clk        (clk),
        .reset_     (rst_n),
        .enable     (a_en),
        .mode       (a_mode),
        .bit_in     (a_bit),
        .bit_valid  (a_val),
        .bit_ready  (a_rdy),
        .i          (a_i),
        .q          (a_q),
        .sym_strobe (a_stb),
        .underrun   (a_und)
    );

    iq_symbol_mapper #(.CLKS_PER_SYM(4), .AMP(AMP)) dut_b (
        .clk        (clk),
        .reset_     (rst_n),
        .enable     (b_en),
        .mode       (b_mode),
        .bit_in     (b_bit),
        .bit_valid  (b_val),
        .bit_ready  (b_rdy),
        .i          (b_i),
        .q          (b_q),
        .sym_strobe (b_stb),
        .underrun   (b_und)
    );

    typedef struct {
        int                cyc;
        logic signed [7:0] i;
        logic signed [7:0] q;
        logic              und;
    } stb_t;

    stb_t              amon[$];
    int                cyc      = 0;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_fail   = 0;
    int                glitches = 0;
    logic              watch_a  = 1'b0;
    logic signed [7:0] prev_i   = '0;
    logic signed [7:0] prev_q   = '0;

    int   la;
    int   bad;
    logic und_seen;
    logic [11:0] seq;
    logic bq[$];
    int   bs_cyc[$];
    int   bs_i[$];
    int   bs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_stb) amon.push_back('{cyc, a_i, a_q, a_und});
    end

    // Outputs of dut_a must only move on a strobe while a run is being watched.
    always @(negedge clk) begin
        if (watch_a && !a_stb && (a_i !== prev_i || a_q !== prev_q)) glitches <= glitches + 1;
        prev_i <= a_i;
        prev_q <= a_q;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int lvl(input logic hi, input logic lo);
        return (hi ? 1 : -1) * (lo ? INNER : AMP);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic b);
        int w;
        w     = 0;
        a_bit = b;
        a_val = 1'b1;
        #1;
        while (!a_rdy && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!a_rdy) check("send_ready", int'(a_rdy), 1);
        @(negedge clk);
        a_val = 1'b0;
    endtask

    task automatic wait_a(input int n, input string tag);
        int w;
        w = 0;
        while (amon.size() < n && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        check(tag, amon.size(), n);
    endtask

    initial begin
        a_en = 1'b1; a_mode = 1'b0; a_bit = 1'b0; a_val = 1'b0;
        b_en = 1'b0; b_mode = 1'b0; b_bit = 1'b0; b_val = 1'b0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_i", int'(a_i), 0);
        check("rst_q", int'(a_q), 0);
        check("rst_strobe", int'(a_stb), 0);
        check("rst_underrun", int'(a_und), 0);
        check("rst_ready", int'(a_rdy), 0);

        // QPSK single symbol, then starvation
        @(negedge clk);
        rst_n   = 1'b1;
        watch_a = 1'b1;
        @(negedge clk);
        send_a(1'b1);
        send_a(1'b0);
        la = cyc;
        wait_a(3, "qpsk_strobes");
        if (amon.size() >= 3) begin
            check("qpsk_latency", amon[0].cyc - la, 2);
            check("qpsk_i", int'(amon[0].i), AMP);
            check("qpsk_q", int'(amon[0].q), -AMP);
            check("qpsk_underrun", int'(amon[0].und), 0);
            check("qpsk_period", amon[1].cyc - amon[0].cyc, 32);
            check("starve_i", int'(amon[1].i), 0);
            check("starve_q", int'(amon[1].q), 0);
            check("starve_underrun", int'(amon[1].und), 1);
            check("starve_period", amon[2].cyc - amon[1].cyc, 32);
        end
        check("underrun_sticky", int'(a_und), 1);
        watch_a = 1'b0;
        a_en    = 1'b0;
        @(negedge clk);
        #1;
        check("flush_underrun", int'(a_und), 0);
        check("flush_i", int'(a_i), 0);
        check("flush_ready", int'(a_rdy), 0);

        // 16-QAM continuous, mode toggled mid-run
        amon.delete();
        a_mode  = 1'b1;
        a_en    = 1'b1;
        watch_a = 1'b1;
        @(negedge clk);
        seq = 12'b1001_0111_1100;
        for (int k = 11; k >= 0; k--) begin
            send_a(seq[k]);
            if (k == 4) a_mode = 1'b0;
        end
        #1;
        check("qam_ready_both_full", int'(a_rdy), 0);
        wait_a(3, "qam_strobes");
        if (amon.size() >= 3) begin
            check("qam0_i", int'(amon[0].i), AMP);
            check("qam0_q", int'(amon[0].q), -INNER);
            check("qam_period1", amon[1].cyc - amon[0].cyc, 32);
            check("qam1_i", int'(amon[1].i), -INNER);
            check("qam1_q", int'(amon[1].q), INNER);
            check("qam_period2", amon[2].cyc - amon[1].cyc, 32);
            check("qam2_i", int'(amon[2].i), INNER);
            check("qam2_q", int'(amon[2].q), -AMP);
            check("qam_no_underrun", int'(amon[2].und), 0);
        end

        // Partial symbol dropped by enable=0; new mode (QPSK) applies after IDLE
        send_a(1'b0);
        watch_a = 1'b0;
        a_en    = 1'b0;
        @(negedge clk);
        #1;
        check("drop_i", int'(a_i), 0);
        a_en = 1'b1;
        amon.delete();
        @(negedge clk);
        send_a(1'b1);
        send_a(1'b1);
        la = cyc;
        send_a(1'b0);
        wait_a(1, "remode_strobe");
        if (amon.size() >= 1) begin
            check("remode_latency", amon[0].cyc - la, 2);
            check("remode_i", int'(amon[0].i), AMP);
            check("remode_q", int'(amon[0].q), AMP);
        end

        // Asynchronous reset while the strobe is high and a partial symbol is held
        rst_n = 1'b0;
        #1;
        check("arst_i", int'(a_i), 0);
        check("arst_q", int'(a_q), 0);
        check("arst_strobe", int'(a_stb), 0);
        check("arst_ready", int'(a_rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        amon.delete();
        @(negedge clk);
        send_a(1'b1);
        send_a(1'b0);
        la = cyc;
        wait_a(1, "post_reset_strobe");
        if (amon.size() >= 1) begin
            check("post_reset_latency", amon[0].cyc - la, 2);
            check("post_reset_i", int'(amon[0].i), AMP);
            check("post_reset_q", int'(amon[0].q), -AMP);
        end
        a_en = 1'b0;
        check("hold_stable", glitches, 0);

        // Random 16-QAM stream at 4 clocks/symbol with bit_valid held high
        b_mode = 1'b1;
        b_en   = 1'b1;
        @(negedge clk);
        und_seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            #1;
            if (b_stb) begin
                bs_cyc.push_back(cyc);
                bs_i.push_back(int'(b_i));
                bs_q.push_back(int'(b_q));
            end
            if (b_und) und_seen = 1'b1;
            if (bs_cyc.size() >= 64) break;
            b_val = 1'b1;
            b_bit = 1'($urandom_range(1, 0));
            #1;
            if (b_rdy) bq.push_back(b_bit);
        end
        b_val = 1'b0;
        check("bp_symbols", bs_cyc.size(), 64);
        for (int k = 0; k < bs_cyc.size() && 4 * k + 3 < bq.size(); k++) begin
            check($sformatf("bp_i%0d", k), bs_i[k], lvl(bq[4 * k], bq[4 * k + 1]));
            check($sformatf("bp_q%0d", k), bs_q[k], lvl(bq[4 * k + 2], bq[4 * k + 3]));
        end
        bad = 0;
        for (int k = 1; k < bs_cyc.size(); k++) begin
            if (bs_cyc[k] - bs_cyc[k - 1] != 4) bad++;
        end
        check("bp_period", bad, 0);
        check("bp_underrun", int'(und_seen), 0);
        b_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
